// File: rtl/chacha_stream_ctrl.sv
// chacha_stream_ctrl: initiator side of the chacha_core init/next handshake.
// Packs a 32-bit word stream into 512-bit blocks, issues one core request per
// block with an incrementing 64-bit block counter, then replays the core result
// as a 32-bit output stream. One block in flight at a time.
//
// Handshakes: a word moves on s_* when s_valid && s_ready at a rising edge, and
// on m_* when m_valid && m_ready. m_valid, m_data and m_last stay stable until
// the word is taken. core_init/core_next are single-cycle strobes. The core
// result is only looked at while waiting for it.
module chacha_stream_ctrl #(
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] cfg_key,
  input  logic [63:0]  cfg_iv,
  input  logic [63:0]  cfg_ctr,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [31:0]  m_data,
  output logic         m_last,
  output logic         core_init,
  output logic         core_next,
  output logic [255:0] core_key,
  output logic [63:0]  core_ctr,
  output logic [63:0]  core_iv,
  output logic [511:0] core_data_in,
  input  logic         core_ready,
  input  logic         core_data_valid,
  input  logic [511:0] core_data_out,
  output logic         busy,
  output logic         err_timeout
);

  localparam int TW = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ISSUE,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  state_t         state;
  logic [3:0]     idx;
  logic [3:0]     oidx;
  logic [4:0]     nwords;
  logic           first_blk;
  logic           last_blk;
  logic [TW-1:0]  wait_cnt;
  // Holds the packed input block until the core answers, then the result.
  logic [511:0]   blk;
  logic           s_fire;
  logic           m_fire;

  // Word i lives at bits [511-32*i -: 32]; this is that top bit.
  function automatic logic [8:0] word_base(input logic [3:0] i);
    return {~i, 5'h1F};
  endfunction

  assign core_data_in = blk;
  assign s_fire       = s_valid && s_ready;
  assign m_fire       = m_valid && m_ready;

  // Main controller: state, buffers and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      oidx        <= '0;
      nwords      <= '0;
      first_blk   <= 1'b0;
      last_blk    <= 1'b0;
      wait_cnt    <= '0;
      blk         <= '0;
      s_ready     <= 1'b1;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
      core_init   <= 1'b0;
      core_next   <= 1'b0;
      core_key    <= '0;
      core_ctr    <= '0;
      core_iv     <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      core_init   <= 1'b0;
      core_next   <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s_fire) begin
            core_key  <= cfg_key;
            core_iv   <= cfg_iv;
            core_ctr  <= cfg_ctr;
            blk       <= {s_data, 480'd0};
            first_blk <= 1'b1;
            last_blk  <= s_last;
            busy      <= 1'b1;
            if (s_last) begin
              nwords  <= 5'd1;
              s_ready <= 1'b0;
              state   <= ST_ISSUE;
            end else begin
              idx     <= 4'd1;
              state   <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (s_fire) begin
            blk[word_base(idx) -: 32] <= s_data;
            if (s_last || idx == 4'd15) begin
              nwords   <= {1'b0, idx} + 5'd1;
              last_blk <= s_last;
              s_ready  <= 1'b0;
              state    <= ST_ISSUE;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        ST_ISSUE: begin
          if (core_ready) begin
            core_init <= first_blk;
            core_next <= !first_blk;
            wait_cnt  <= '0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (core_data_valid) begin
            blk     <= core_data_out;
            oidx    <= '0;
            m_valid <= 1'b1;
            m_data  <= core_data_out[511:480];
            m_last  <= last_blk && (nwords == 5'd1);
            state   <= ST_DRAIN;
          end else if (wait_cnt == TW'(WAIT_TIMEOUT - 1)) begin
            // Core never answered: drop the packet, keep the counter as is.
            err_timeout <= 1'b1;
            blk         <= '0;
            idx         <= '0;
            s_ready     <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        ST_DRAIN: begin
          if (m_fire) begin
            if ({1'b0, oidx} + 5'd1 == nwords) begin
              m_valid   <= 1'b0;
              m_data    <= '0;
              m_last    <= 1'b0;
              core_ctr  <= core_ctr + 64'd1;
              first_blk <= 1'b0;
              blk       <= '0;
              idx       <= '0;
              s_ready   <= 1'b1;
              if (last_blk) begin
                busy  <= 1'b0;
                state <= ST_IDLE;
              end else begin
                state <= ST_FILL;
              end
            end else begin
              oidx   <= oidx + 4'd1;
              m_data <= blk[word_base(oidx + 4'd1) -: 32];
              m_last <= last_blk && ({1'b0, oidx} + 5'd2 == nwords);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// Directed bench for chacha_stream_ctrl with a small core model that answers
// each request two cycles later with data_in ^ {16{32'hA5A5A5A5}}.
`timescale 1ns/1ps
module tb_chacha_stream_ctrl;

  localparam logic [31:0] PAT = 32'hA5A5_A5A5;

  // Clock and reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [255:0] cfg_key = '0;
  logic [63:0]  cfg_iv = '0;
  logic [63:0]  cfg_ctr = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  s_data = '0;
  logic         s_last = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic [31:0]  m_data;
  logic         m_last;
  logic         core_init;
  logic         core_next;
  logic [255:0] core_key;
  logic [63:0]  core_ctr;
  logic [63:0]  core_iv;
  logic [511:0] core_data_in;
  logic         core_ready = 1'b1;
  logic         core_data_valid = 1'b0;
  logic [511:0] core_data_out = '0;
  logic         busy;
  logic         err_timeout;

  chacha_stream_ctrl #(.WAIT_TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .cfg_key(cfg_key), .cfg_iv(cfg_iv), .cfg_ctr(cfg_ctr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .core_init(core_init), .core_next(core_next), .core_key(core_key),
    .core_ctr(core_ctr), .core_iv(core_iv), .core_data_in(core_data_in),
    .core_ready(core_ready), .core_data_valid(core_data_valid),
    .core_data_out(core_data_out), .busy(busy), .err_timeout(err_timeout)
  );

  // Scoreboard state
  int checks = 0;
  int errors = 0;
  logic [31:0]  exp_q[$];
  logic         exp_last_q[$];
  logic [31:0]  got_q[$];
  logic         got_last_q[$];
  logic         req_init_q[$];
  logic [63:0]  req_ctr_q[$];
  logic [511:0] req_data_q[$];
  logic [255:0] req_key_q[$];
  logic [63:0]  req_iv_q[$];
  int           resp_cnt = 0;
  logic [511:0] resp_data = '0;
  logic         core_en = 1'b1;
  int           mvalid_cnt = 0;
  int           overlap_cnt = 0;

  // Core model and output monitor, on the falling edge.
  always @(negedge clk) begin
    core_data_valid = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt = resp_cnt - 1;
      if (resp_cnt == 0) begin
        core_data_valid = 1'b1;
        core_data_out   = resp_data;
      end
    end
    if (!reset) begin
      if (core_init || core_next) begin
        req_init_q.push_back(core_init);
        req_ctr_q.push_back(core_ctr);
        req_data_q.push_back(core_data_in);
        req_key_q.push_back(core_key);
        req_iv_q.push_back(core_iv);
        if (core_en) begin
          resp_data = core_data_in ^ {16{PAT}};
          resp_cnt  = 2;
        end
      end
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        got_last_q.push_back(m_last);
      end
      if (m_valid) mvalid_cnt++;
      if (m_valid && s_ready) overlap_cnt++;
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=no_finish required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: entered and left at posedge+1.
  task automatic send_word(input logic [31:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int k = 0; k < 300; k++) begin
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("send_accept", ok, 1'b1);
  endtask

  task automatic send_packet(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back((base + 32'(i)) ^ PAT);
      exp_last_q.push_back(i == n - 1);
      send_word(base + 32'(i), i == n - 1);
    end
  endtask

  task automatic wait_outputs(input int n);
    for (int k = 0; k < 600 && got_q.size() < n; k++) begin
      @(posedge clk); #1;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic compare_outputs(input string tag);
    int n;
    check({tag, "_count"}, 512'(got_q.size()), 512'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), 512'(got_q[i]), 512'(exp_q[i]));
      check($sformatf("%s_last%0d", tag, i), 512'(got_last_q[i]), 512'(exp_last_q[i]));
    end
    got_q.delete(); got_last_q.delete(); exp_q.delete(); exp_last_q.delete();
  endtask

  task automatic clear_reqs();
    req_init_q.delete(); req_ctr_q.delete(); req_data_q.delete();
    req_key_q.delete(); req_iv_q.delete();
  endtask

  // Directed sequence
  initial begin
    int k;
    logic [31:0] held;
    bit seen;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_core_init", core_init, 1'b0);
    check("rst_core_ctr", core_ctr, 64'd0);
    check("rst_err", err_timeout, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 16-word packet, single block
    cfg_key = {8{32'h0123_4567}};
    cfg_iv  = 64'hCAFE_F00D_0000_0001;
    cfg_ctr = 64'd5;
    clear_reqs();
    send_packet(16, 32'h1000_0000);
    wait_outputs(16);
    check("p16_reqs", 512'(req_init_q.size()), 512'd1);
    check("p16_init", req_init_q[0], 1'b1);
    check("p16_ctr", req_ctr_q[0], 64'd5);
    check("p16_key", req_key_q[0], {8{32'h0123_4567}});
    check("p16_iv", req_iv_q[0], 64'hCAFE_F00D_0000_0001);
    check("p16_w0", req_data_q[0][511:480], 32'h1000_0000);
    check("p16_w15", req_data_q[0][31:0], 32'h1000_000F);
    compare_outputs("p16");
    check("p16_ctr_after", core_ctr, 64'd6);
    check("p16_busy", busy, 1'b0);
    check("p16_s_ready", s_ready, 1'b1);

    // 40-word packet, three blocks with a short last block
    clear_reqs();
    send_packet(40, 32'h2000_0000);
    wait_outputs(40);
    check("p40_reqs", 512'(req_init_q.size()), 512'd3);
    check("p40_init0", req_init_q[0], 1'b1);
    check("p40_init1", req_init_q[1], 1'b0);
    check("p40_init2", req_init_q[2], 1'b0);
    check("p40_ctr0", req_ctr_q[0], 64'd5);
    check("p40_ctr1", req_ctr_q[1], 64'd6);
    check("p40_ctr2", req_ctr_q[2], 64'd7);
    check("p40_b2_w0", req_data_q[2][511:480], 32'h2000_0020);
    check("p40_b2_w7", req_data_q[2][287:256], 32'h2000_0027);
    check("p40_pad", req_data_q[2][255:0], 256'd0);
    compare_outputs("p40");

    // Counter wrap
    cfg_ctr = 64'hFFFF_FFFF_FFFF_FFFF;
    clear_reqs();
    send_packet(32, 32'h3000_0000);
    wait_outputs(32);
    check("wrap_reqs", 512'(req_init_q.size()), 512'd2);
    check("wrap_ctr0", req_ctr_q[0], 64'hFFFF_FFFF_FFFF_FFFF);
    check("wrap_next", req_init_q[1], 1'b0);
    check("wrap_ctr1", req_ctr_q[1], 64'd0);
    compare_outputs("wrap");

    // Backpressure mid-drain
    cfg_ctr = 64'd9;
    clear_reqs();
    send_packet(16, 32'h4000_0000);
    for (k = 0; k < 300 && got_q.size() < 5; k++) begin
      @(posedge clk); #1;
    end
    m_ready = 1'b0;
    held = m_data;
    check("bp_held_word", held, 32'h4000_0005 ^ PAT);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_valid%0d", i), m_valid, 1'b1);
      check($sformatf("bp_data%0d", i), m_data, held);
      check($sformatf("bp_s_ready%0d", i), s_ready, 1'b0);
    end
    check("bp_no_extra", 512'(got_q.size()), 512'd5);
    m_ready = 1'b1;
    wait_outputs(16);
    compare_outputs("bp");
    check("overlap", 512'(overlap_cnt), 512'd0);

    // Core never answers
    core_en = 1'b0;
    cfg_ctr = 64'd100;
    clear_reqs();
    send_packet(16, 32'h5000_0000);
    exp_q.delete(); exp_last_q.delete();
    mvalid_cnt = 0;
    seen = 1'b0;
    for (k = 0; k < 20; k++) begin
      if (core_init) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("to_req_seen", seen, 1'b1);
    k = 0;
    seen = 1'b0;
    while (k < 200) begin
      @(posedge clk); #1;
      k++;
      if (err_timeout) begin
        seen = 1'b1;
        break;
      end
    end
    check("to_err_seen", seen, 1'b1);
    check("to_err_cycles", 512'(k), 512'd64);
    check("to_busy", busy, 1'b0);
    check("to_s_ready", s_ready, 1'b1);
    check("to_ctr", core_ctr, 64'd100);
    @(posedge clk); #1;
    check("to_err_pulse", err_timeout, 1'b0);
    check("to_no_m_valid", 512'(mvalid_cnt), 512'd0);
    core_en = 1'b1;

    // Reset during FILL, then a fresh 1-word packet
    cfg_ctr = 64'd50;
    clear_reqs();
    for (int i = 0; i < 7; i++) send_word(32'h6000_0000 + 32'(i), 1'b0);
    check("mid_busy", busy, 1'b1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("mr_s_ready", s_ready, 1'b1);
    check("mr_busy", busy, 1'b0);
    check("mr_m_valid", m_valid, 1'b0);
    check("mr_ctr", core_ctr, 64'd0);
    cfg_key = {8{32'h89AB_CDEF}};
    cfg_iv  = 64'h1111_2222_3333_4444;
    cfg_ctr = 64'h1234;
    clear_reqs();
    mvalid_cnt = 0;
    send_packet(1, 32'h7000_0000);
    wait_outputs(1);
    check("one_reqs", 512'(req_init_q.size()), 512'd1);
    check("one_init", req_init_q[0], 1'b1);
    check("one_ctr", req_ctr_q[0], 64'h1234);
    check("one_key", req_key_q[0], {8{32'h89AB_CDEF}});
    check("one_iv", req_iv_q[0], 64'h1111_2222_3333_4444);
    check("one_block", req_data_q[0], {32'h7000_0000, 480'd0});
    compare_outputs("one");
    check("one_ctr_after", core_ctr, 64'h1235);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
